// File: rtl/perf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_pkg                                                             |
// | Shared slot map, FSM state encodings and sizes for the perf snapshot.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package perf_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
    localparam int DATA_W    = 32;
    localparam int STATE_W   = 3;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARB    = 3'd1;
    localparam logic [STATE_W-1:0] ST_READ   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CLEAR  = 3'd3;
    localparam logic [STATE_W-1:0] ST_STREAM = 3'd4;
    localparam logic [STATE_W-1:0] ST_FIN    = 3'd5;

    // 0xFFFFFFE8 and 0xFFFFFFEC are deliberately absent from the map.
    function automatic logic [DATA_W-1:0] slot_addr(input logic [SLOT_W-1:0] slot);
        logic [DATA_W-1:0] addr;
        case (slot)
            3'd0:    addr = 32'hFFFF_FFD8;
            3'd1:    addr = 32'hFFFF_FFDC;
            3'd2:    addr = 32'hFFFF_FFE0;
            3'd3:    addr = 32'hFFFF_FFE4;
            3'd4:    addr = 32'hFFFF_FFF0;
            3'd5:    addr = 32'hFFFF_FFF4;
            3'd6:    addr = 32'hFFFF_FFF8;
            default: addr = 32'hFFFF_FFFC;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snapshot_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snapshot_buffer                                                      |
// | 8 x 32 capture store, one write port, one combinational read port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module snapshot_buffer
    import perf_pkg::*;
(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [SLOT_W-1:0] i_wr_slot,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [SLOT_W-1:0] i_rd_slot,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_SLOTS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_slot] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_slot];

endmodule
`default_nettype wire

// File: rtl/perf_snapshot_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | perf_snapshot_reader                                                 |
// | Arbitrates for the counter MMIO path, reads (and optionally clears)  |
// | eight perf counters, then streams the captured values out.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module perf_snapshot_reader
    import perf_pkg::*;
#(
    parameter bit CLEAR_EN = 1'b1,
    parameter int TIMEOUT  = 255
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        counter_read,
    output logic        counter_write,
    output logic [31:0] counter_addr,
    input  logic [31:0] counter_data,
    output logic        snap_valid,
    input  logic        snap_ready,
    output logic [2:0]  snap_index,
    output logic [31:0] snap_data,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    logic [STATE_W-1:0] r_state;
    logic [SLOT_W-1:0]  r_slot;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_abort;
    logic               r_resume_clear;

    logic               w_on_bus;
    logic [DATA_W-1:0]  w_buf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_slot         <= '0;
            r_wait         <= '0;
            r_abort        <= 1'b0;
            r_resume_clear <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state        <= ST_ARB;
                        r_slot         <= '0;
                        r_wait         <= '0;
                        r_abort        <= 1'b0;
                        r_resume_clear <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (bus_gnt) begin
                        r_state <= r_resume_clear ? ST_CLEAR : ST_READ;
                        r_wait  <= '0;
                    end else if (r_wait >= C_WAIT_LAST) begin
                        r_state <= ST_FIN;
                        r_abort <= 1'b1;
                        r_wait  <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_READ: begin
                    // Losing the grant re-arbitrates and retries the same slot.
                    if (!bus_gnt) begin
                        r_state        <= ST_ARB;
                        r_wait         <= '0;
                        r_resume_clear <= 1'b0;
                    end else if (CLEAR_EN) begin
                        r_state <= ST_CLEAR;
                    end else if (r_slot == SLOT_LAST) begin
                        r_state <= ST_STREAM;
                        r_slot  <= '0;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!bus_gnt) begin
                        r_state        <= ST_ARB;
                        r_wait         <= '0;
                        r_resume_clear <= 1'b1;
                    end else if (r_slot == SLOT_LAST) begin
                        r_state <= ST_STREAM;
                        r_slot  <= '0;
                    end else begin
                        r_state <= ST_READ;
                        r_slot  <= r_slot + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (snap_ready) begin
                        if (r_slot == SLOT_LAST) begin
                            r_state <= ST_FIN;
                            r_slot  <= '0;
                        end else begin
                            r_slot <= r_slot + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_abort <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    snapshot_buffer u_buffer (
        .clk       (clk),
        .i_wr_en   (counter_read),
        .i_wr_slot (r_slot),
        .i_wr_data (counter_data),
        .i_rd_slot (r_slot),
        .o_rd_data (w_buf_data)
    );

    assign w_on_bus      = (r_state == ST_READ) || (r_state == ST_CLEAR);

    assign busy          = (r_state != ST_IDLE);
    assign bus_req       = (r_state == ST_ARB) || w_on_bus;
    assign counter_read  = (r_state == ST_READ) && bus_gnt;
    assign counter_write = (r_state == ST_CLEAR) && bus_gnt;
    assign counter_addr  = w_on_bus ? slot_addr(r_slot) : '0;

    assign snap_valid    = (r_state == ST_STREAM);
    assign snap_index    = snap_valid ? r_slot : '0;
    assign snap_data     = snap_valid ? w_buf_data : '0;

    assign done          = (r_state == ST_FIN) && !r_abort;
    assign aborted       = (r_state == ST_FIN) && r_abort;

endmodule
`default_nettype wire

// File: tb/tb_perf_snapshot_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_perf_snapshot_reader                                              |
// | Two instances (clear on / clear off) against a modelled responder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_perf_snapshot_reader;
    import perf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_a, gnt_a, ready_a;
    logic        req_a, rd_a, wr_a, valid_a, busy_a, done_a, abort_a;
    logic [31:0] addr_a, cdata_a, sdata_a;
    logic [2:0]  sidx_a;

    logic        start_b;
    logic        req_b, rd_b, wr_b, valid_b, busy_b, done_b, abort_b;
    logic [31:0] addr_b, cdata_b, sdata_b;
    logic [2:0]  sidx_b;

    perf_snapshot_reader #(.CLEAR_EN(1'b1), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus_req(req_a), .bus_gnt(gnt_a),
        .counter_read(rd_a), .counter_write(wr_a), .counter_addr(addr_a),
        .counter_data(cdata_a), .snap_valid(valid_a), .snap_ready(ready_a),
        .snap_index(sidx_a), .snap_data(sdata_a), .busy(busy_a), .done(done_a),
        .aborted(abort_a)
    );

    perf_snapshot_reader #(.CLEAR_EN(1'b0), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus_req(req_b), .bus_gnt(1'b1),
        .counter_read(rd_b), .counter_write(wr_b), .counter_addr(addr_b),
        .counter_data(cdata_b), .snap_valid(valid_b), .snap_ready(1'b1),
        .snap_index(sidx_b), .snap_data(sdata_b), .busy(busy_b), .done(done_b),
        .aborted(abort_b)
    );

    function automatic logic [31:0] exp_addr(input int k);
        case (k)
            0: return 32'hFFFF_FFD8;
            1: return 32'hFFFF_FFDC;
            2: return 32'hFFFF_FFE0;
            3: return 32'hFFFF_FFE4;
            4: return 32'hFFFF_FFF0;
            5: return 32'hFFFF_FFF4;
            6: return 32'hFFFF_FFF8;
            7: return 32'hFFFF_FFFC;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] slot_of(input logic [31:0] a);
        case (a)
            32'hFFFF_FFD8: return 4'd0;
            32'hFFFF_FFDC: return 4'd1;
            32'hFFFF_FFE0: return 4'd2;
            32'hFFFF_FFE4: return 4'd3;
            32'hFFFF_FFF0: return 4'd4;
            32'hFFFF_FFF4: return 4'd5;
            32'hFFFF_FFF8: return 4'd6;
            32'hFFFF_FFFC: return 4'd7;
            default:       return 4'b1000;
        endcase
    endfunction

    // Counter responder: data only while the read strobe is up, clear on write.
    logic [31:0] cnt_a [8];
    logic [31:0] cnt_b [8];
    logic [31:0] load_a [8];
    logic [31:0] load_b [8];
    int          reads_a [8];
    int          bad_bus;
    int          wr_b_seen;
    logic        load_now;
    logic [3:0]  sl_a, sl_b;

    assign sl_a    = slot_of(addr_a);
    assign sl_b    = slot_of(addr_b);
    assign cdata_a = (rd_a && !sl_a[3]) ? cnt_a[sl_a[2:0]] : 32'hDEAD_BEEF;
    assign cdata_b = (rd_b && !sl_b[3]) ? cnt_b[sl_b[2:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (load_now) begin
            for (int k = 0; k < 8; k++) begin
                cnt_a[k]   <= load_a[k];
                cnt_b[k]   <= load_b[k];
                reads_a[k] <= 0;
            end
        end else begin
            if (wr_a && !sl_a[3]) cnt_a[sl_a[2:0]] <= 32'd0;
            if (rd_a && !sl_a[3]) reads_a[sl_a[2:0]] <= reads_a[sl_a[2:0]] + 1;
        end
        if (((rd_a || wr_a) && sl_a[3]) || (rd_a && wr_a) ||
            ((rd_b || wr_b) && sl_b[3]) || (rd_b && wr_b))
            bad_bus <= bad_bus + 1;
        if (wr_b) wr_b_seen <= wr_b_seen + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic req, input logic rd, input logic wr,
                                       input logic [31:0] addr, input logic valid,
                                       input logic [2:0] idx, input logic [31:0] data,
                                       input logic bsy, input logic dn, input logic ab);
        return {6'd0, req, rd, wr, addr, valid, idx, data, bsy, dn, ab};
    endfunction

    function automatic logic [79:0] outs_a();
        return mk(req_a, rd_a, wr_a, addr_a, valid_a, sidx_a, sdata_a, busy_a, done_a, abort_a);
    endfunction

    function automatic logic [79:0] outs_b();
        return mk(req_b, rd_b, wr_b, addr_b, valid_b, sidx_b, sdata_b, busy_b, done_b, abort_b);
    endfunction

    task automatic preload(input logic [31:0] base_a, input logic [31:0] base_b);
        for (int k = 0; k < 8; k++) begin
            load_a[k] = base_a + 32'(k);
            load_b[k] = base_b + 32'(k);
        end
        @(posedge clk); #1 load_now = 1'b1;
        @(posedge clk); #1 load_now = 1'b0;
    endtask

    // Results of one dut_a snapshot run.
    logic [2:0]  got_idx [8];
    logic [31:0] got_data [8];
    int          n_words, hold_err, done_cnt, abort_cnt;
    logic [34:0] drop_obs;
    logic [2:0]  rearb_obs;

    task automatic run_a(input int drop_cyc, input bit toggle, input bit mid_start);
        logic        pv_hold;
        logic [34:0] pv;
        bit          pulsed;
        n_words = 0; hold_err = 0; done_cnt = 0; abort_cnt = 0;
        pulsed = 0; pv_hold = 1'b0; pv = '0;
        drop_obs = '1; rearb_obs = '1;
        for (int k = 0; k < 8; k++) begin got_idx[k] = '1; got_data[k] = '1; end
        for (int cyc = 0; cyc < 120 && done_cnt == 0 && abort_cnt == 0; cyc++) begin
            gnt_a   = (cyc != drop_cyc);
            ready_a = toggle ? (cyc % 2 == 0) : 1'b1;
            if (cyc == 0) start_a = 1'b1;
            else begin
                start_a = mid_start && (n_words == 3) && !pulsed;
                if (start_a) pulsed = 1;
            end
            @(negedge clk);
            if (cyc == drop_cyc)     drop_obs  = {req_a, rd_a, wr_a, addr_a};
            if (cyc == drop_cyc + 1) rearb_obs = {req_a, rd_a, wr_a};
            if (pv_hold && (!valid_a || ({sidx_a, sdata_a} != pv))) hold_err++;
            pv_hold = valid_a && !ready_a;
            pv      = {sidx_a, sdata_a};
            if (valid_a && ready_a) begin
                if (n_words < 8) begin
                    got_idx[n_words]  = sidx_a;
                    got_data[n_words] = sdata_a;
                end
                n_words++;
            end
            if (done_a)  done_cnt++;
            if (abort_a) abort_cnt++;
            @(posedge clk); #1;
        end
        start_a = 1'b0; gnt_a = 1'b1; ready_a = 1'b1;
    endtask

    task automatic check_words(input string tag, input logic [31:0] base);
        check({tag, "_nwords"}, 80'(n_words), 80'd8);
        check({tag, "_done"}, 80'(done_cnt), 80'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_word%0d", tag, k), {45'd0, got_idx[k], got_data[k]},
                  {45'd0, 3'(k), base + 32'(k)});
    endtask

    typedef struct packed {
        logic        start;
        logic        gnt;
        logic        ready;
        logic [79:0] exp;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t v(input logic st, input logic [79:0] e);
        vec_t r;
        r.start = st; r.gnt = 1'b1; r.ready = 1'b1; r.exp = e;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] acc;
        int          found, arb_cnt, vseen, got_abort, dne;

        rst_n = 1'b0; start_a = 1'b0; gnt_a = 1'b1; ready_a = 1'b1;
        start_b = 1'b0; load_now = 1'b0;

        // Clear-enabled snapshot, cycle by cycle, counters 1..8.
        vecs[0] = v(1'b1, mk(0, 0, 0, 32'd0, 0, 3'd0, 32'd0, 0, 0, 0));
        vecs[1] = v(1'b0, mk(1, 0, 0, 32'd0, 0, 3'd0, 32'd0, 1, 0, 0));
        for (int s = 0; s < 8; s++) begin
            vecs[2 + 2*s] = v(1'b0, mk(1, 1, 0, exp_addr(s), 0, 3'd0, 32'd0, 1, 0, 0));
            vecs[3 + 2*s] = v(1'b0, mk(1, 0, 1, exp_addr(s), 0, 3'd0, 32'd0, 1, 0, 0));
            vecs[18 + s]  = v(1'b0, mk(0, 0, 0, 32'd0, 1, 3'(s), 32'(s + 1), 1, 0, 0));
        end
        vecs[26] = v(1'b0, mk(0, 0, 0, 32'd0, 0, 3'd0, 32'd0, 1, 1, 0));
        vecs[27] = v(1'b0, mk(0, 0, 0, 32'd0, 0, 3'd0, 32'd0, 0, 0, 0));

        #3;
        check("reset_outs_a", outs_a(), 80'd0);
        check("reset_outs_b", outs_b(), 80'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        preload(32'd1, 32'd100);

        for (int i = 0; i < 28; i++) begin
            start_a = vecs[i].start; gnt_a = vecs[i].gnt; ready_a = vecs[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs_a(), vecs[i].exp);
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        acc = '0;
        for (int k = 0; k < 8; k++) acc = acc | cnt_a[k];
        check("cleared_after", 80'(acc), 80'd0);

        // No-clear instance: eight back-to-back reads, no write strobes.
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        found = 0;
        for (int n = 0; n < 10 && found == 0; n++) begin
            @(negedge clk);
            if (rd_b) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("b_read_found", 80'(found), 80'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b_read%0d", k), 80'({rd_b, wr_b, addr_b}), 80'({2'b10, exp_addr(k)}));
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b_word%0d", k), 80'({valid_b, sidx_b, sdata_b}),
                  80'({1'b1, 3'(k), 32'(100 + k)}));
            @(negedge clk);
        end
        check("b_done", 80'(done_b), 80'd1);
        check("b_no_write", 80'(wr_b_seen), 80'd0);
        @(posedge clk); #1;

        // Grant never arrives: abort after four arbitration cycles.
        gnt_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        arb_cnt = 0; vseen = 0; got_abort = 0;
        for (int n = 0; n < 20 && got_abort == 0; n++) begin
            @(negedge clk);
            if (abort_a) got_abort = 1;
            else begin
                if (req_a) arb_cnt++;
                if (valid_a) vseen++;
                @(posedge clk); #1;
            end
        end
        check("abort_seen", 80'(got_abort), 80'd1);
        check("abort_arb_cycles", 80'(arb_cnt), 80'd4);
        check("abort_no_done_no_valid", 80'({done_a, valid_a, 8'(vseen)}), 80'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_then_idle", 80'({busy_a, abort_a}), 80'd0);
        @(posedge clk); #1 gnt_a = 1'b1;

        // Grant dropped in the slot-3 read cycle.
        preload(32'h8000_0010, 32'd100);
        run_a(8, 1'b0, 1'b0);
        check("drop_cycle_obs", 80'(drop_obs), 80'({3'b100, 32'hFFFF_FFE4}));
        check("drop_rearb_obs", 80'(rearb_obs), 80'(3'b100));
        for (int k = 0; k < 8; k++)
            check($sformatf("drop_reads%0d", k), 80'(reads_a[k]), 80'd1);
        check_words("drop", 32'h8000_0010);

        // Backpressured stream with a stray start mid-stream.
        preload(32'h0000_0200, 32'd100);
        run_a(-1, 1'b1, 1'b1);
        check_words("toggle", 32'h0000_0200);
        check("toggle_hold", 80'(hold_err), 80'd0);
        @(negedge clk);
        check("toggle_idle1", 80'(busy_a), 80'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("toggle_idle2", 80'(busy_a), 80'd0);
        @(posedge clk); #1;

        // Reset asserted while clearing slot 5.
        preload(32'h0000_0300, 32'd100);
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        #1;
        check("in_clear5", 80'({wr_a, addr_a}), 80'({1'b1, 32'hFFFF_FFF4}));
        rst_n = 1'b0;
        #1;
        check("rst_outs_immediate", outs_a(), 80'd0);
        dne = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_a || abort_a || busy_a) dne++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        check("rst_no_done", 80'(dne), 80'd0);
        preload(32'h0000_0400, 32'd100);
        run_a(-1, 1'b0, 1'b0);
        check_words("after_rst", 32'h0000_0400);

        check("bus_protocol", 80'(bad_bus), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_snapshot_reader.md
PERF_SNAPSHOT_READER -- requirements
Module: perf_snapshot_reader

Interface
REQ-001 The block SHALL have parameter CLEAR_EN, default 1: when 1, each counter is cleared immediately after it is read.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: the maximum number of cycles to wait for a bus grant before abort.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: one-cycle request to take a snapshot.
REQ-006 Port bus_req, output, 1 bit: requests ownership of the counter MMIO path.
REQ-007 Port bus_gnt, input, 1 bit: ownership granted for this cycle.
REQ-008 Port counter_read, output, 1 bit: read strobe to the counter responder.
REQ-009 Port counter_write, output, 1 bit: clear strobe to the counter responder.
REQ-010 Port counter_addr, output, 32 bits: counter MMIO address.
REQ-011 Port counter_data, input, 32 bits: combinational read data, valid in the same cycle as counter_read.
REQ-012 Port snap_valid, output, 1 bit: a stream word is available.
REQ-013 Port snap_ready, input, 1 bit: the consumer accepts the word.
REQ-014 Port snap_index, output, 3 bits: counter slot 0-7.
REQ-015 Port snap_data, output, 32 bits: the captured counter value.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.
REQ-017 Port done, output, 1 bit: one-cycle pulse on completion.
REQ-018 Port aborted, output, 1 bit: one-cycle pulse on grant timeout.

Function
REQ-019 Slot-to-address map SHALL be fixed: 0=FFFFFFD8 (I$ miss), 1=DC (I$ hit), 2=E0 (D$ miss), 3=E4 (D$ hit), 4=F0 (br mispredict), 5=F4 (br), 6=F8 (load stall), 7=FC (stall). E8 and EC are never accessed.
REQ-020 State machine SHALL use states IDLE, ARB, READ, CLEAR, STREAM, FIN.
REQ-021 IDLE: start=1 -> ARB with slot=0 and wait counter=0; start is ignored in every other state.
REQ-022 ARB: bus_req=1 and wait counter increments each cycle; bus_gnt=1 -> READ; wait counter reaching TIMEOUT with no grant -> FIN with abort flag set.
REQ-023 READ (bus_gnt must be 1): counter_read=1 and counter_addr=map[slot], and counter_data is captured into buffer[slot] at the end of the same cycle (1-cycle latency per read).
REQ-023a If bus_gnt is 0 in READ, no strobe SHALL be driven, no capture SHALL occur, and the FSM SHALL return to ARB with the wait counter cleared.
REQ-024 READ transitions: CLEAR_EN=1 -> CLEAR; else slot<7 -> READ with slot+1; slot=7 -> STREAM.
REQ-025 CLEAR: counter_write=1 with the same address while bus_gnt=1; then slot<7 -> READ with slot+1, else STREAM. Grant loss SHALL be handled as in REQ-023a, returning to CLEAR after re-arbitration.
REQ-026 An event that increments a counter in its CLEAR cycle is lost; this is accepted behaviour and is not compensated.
REQ-027 bus_req SHALL stay high from ARB through the last READ/CLEAR and drop on entry to STREAM.
REQ-028 counter_read and counter_write SHALL never be high together, and SHALL be 0 outside READ/CLEAR.
REQ-029 STREAM: snap_valid=1 with snap_index=slot and snap_data=buffer[slot], with slot restarting at 0; slot advances only on snap_valid&snap_ready; index, data and valid SHALL hold stable while snap_ready=0; the transfer of slot 7 -> FIN.
REQ-030 FIN: done=1 (abort flag clear) or aborted=1 (abort flag set) for exactly one cycle, then IDLE; abort SHALL produce no stream words.
REQ-031 The snapshot buffer SHALL be 8 x 32 bits; values are unsigned and stored unmodified.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, slot 0, wait counter 0, abort flag 0, and all outputs 0 (including counter_addr and snap_data).
REQ-033 Reset mid-snapshot SHALL abandon it with no done/aborted pulse; buffer contents need not be reset.

Structure
REQ-034 The slot-to-address table, the state enum and NUM_SLOTS=8 SHALL live in a shared package (perf_pkg) that the counter responder also imports.
REQ-035 The buffer SHALL be one sub-module, snapshot_buffer (8x32, 1 write port, 1 combinational read port).

Verification
REQ-036 CLEAR_EN=1, gnt tied 1, counters preloaded 1..8: start -> reads and clears interleaved over 16 cycles, stream 1..8 at slots 0-7, all counters read 0 afterwards, one done pulse.
REQ-037 CLEAR_EN=0, gnt tied 1: start -> 8 consecutive read cycles with addresses D8, DC, E0, E4, F0, F4, F8, FC and counter_write never 1.
REQ-038 gnt held 0, TIMEOUT=4: start -> aborted pulse after 4 ARB cycles, snap_valid never 1, busy drops the next cycle.
REQ-039 gnt deasserted during slot 3 READ: no capture and no strobe that cycle, re-arbitration, and slot 3 is still read exactly once with the correct value.
REQ-040 snap_ready toggled 1010...: each of the 8 words appears once in order and is stable while ready=0; start pulsed mid-stream is ignored.
REQ-041 rst_n asserted during CLEAR of slot 5: all outputs 0 immediately, no done pulse; a new start afterwards completes normally.
